// File: rtl/pcileech_fifo_rx_demux.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_fifo_rx_demux
// Description : Receive-side demultiplexer between the FT601 RX FIFO and the
//               PCIe controller. Each tagged 64-bit host word is checked for
//               the magic byte (8'h77) and its type field. Type 2'b11 words go
//               to the TLP stream and type 2'b00 words go to the CFG stream.
//               All other words are dropped and counted. Each output stream
//               has a 2-entry first-word-fall-through skid buffer.
//
//               Optional feature macro: PCILEECH_RX_TLP_CHECK_EN
//                 defined   : a TLP framing FSM limits each TLP to MAX_TLP_DW
//                             words. It forces tlast (bit 10) on the word that
//                             hits the limit and sets sticky tlp_err.
//                 undefined : TLP words pass bit-exact and tlp_err is 0.
//
// Ports       : user_clk, user_reset_n     clock, sync active-low reset
//               fifo_rx_data/valid/ready   host word input stream
//               pcie_tlp_rx_data/valid/ready  TLP output stream
//               pcie_cfg_rx_data/valid/ready  CFG output stream
//               drop_cnt                   saturating count of dropped words
//               tlp_err                    sticky oversize-TLP flag
// Revision    : 1.0 - initial release
// ============================================================================

// 2-deep FWFT skid buffer. Slot 0 is always the head, so the output is
// taken directly from a register.
module pcileech_fifo_rx_skid #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic [1:0]   cnt
);
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         pop;

    assign pop   = valid && ready;
    assign valid = (cnt != 2'd0);
    assign data  = slot0;

    // The producer never pushes into a full buffer: its ready is decoded
    // from this count, so a push with cnt==2 cannot occur.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever
                    // remains after the pop.
                    if (cnt == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

module pcileech_fifo_rx_demux #(
    parameter int MAX_TLP_DW = 1028,
    parameter int CNT_W      = 16
) (
    input  logic             user_clk,
    input  logic             user_reset_n,
    input  logic [63:0]      fifo_rx_data,
    input  logic             fifo_rx_valid,
    output logic             fifo_rx_ready,
    output logic [63:0]      pcie_tlp_rx_data,
    output logic             pcie_tlp_rx_valid,
    input  logic             pcie_tlp_rx_ready,
    output logic [63:0]      pcie_cfg_rx_data,
    output logic             pcie_cfg_rx_valid,
    input  logic             pcie_cfg_rx_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             tlp_err
);
    logic [1:0]  tlp_cnt;
    logic [1:0]  cfg_cnt;
    logic        accept;
    logic        magic_ok;
    logic        is_tlp;
    logic        is_cfg;
    logic        is_drop;
    logic [63:0] tlp_push_data;

    // Ready comes only from registered counts, so there is no combinational
    // path from either downstream ready to the upstream ready. A full buffer
    // therefore stalls both streams.
    assign fifo_rx_ready = (tlp_cnt < 2'd2) && (cfg_cnt < 2'd2);
    assign accept        = fifo_rx_valid && fifo_rx_ready;
    assign magic_ok      = (fifo_rx_data[7:0] == 8'h77);
    assign is_tlp        = accept && magic_ok && (fifo_rx_data[9:8] == 2'b11);
    assign is_cfg        = accept && magic_ok && (fifo_rx_data[9:8] == 2'b00);
    assign is_drop       = accept && !is_tlp && !is_cfg;

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            drop_cnt <= '0;
        end else if (is_drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef PCILEECH_RX_TLP_CHECK_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam int DW_W = $clog2(MAX_TLP_DW + 1);

    state_t          state;
    state_t          state_nxt;
    logic [DW_W-1:0] dw_cnt;
    logic [DW_W-1:0] dw_nxt;
    logic [DW_W-1:0] dw_new;
    logic            force_last;

    always_comb begin
        state_nxt  = state;
        dw_nxt     = dw_cnt;
        force_last = 1'b0;
        // The first word of a TLP restarts the count at 1.
        dw_new     = (state == ST_IDLE) ? DW_W'(1) : (dw_cnt + DW_W'(1));
        if (is_tlp) begin
            dw_nxt = dw_new;
            if (fifo_rx_data[10]) begin
                state_nxt = ST_IDLE;
            end else if (dw_new == DW_W'(MAX_TLP_DW)) begin
                // Oversize TLP: terminate it here so the controller never
                // sees an unbounded frame.
                force_last = 1'b1;
                state_nxt  = ST_IDLE;
            end else begin
                state_nxt = ST_BODY;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            state   <= ST_IDLE;
            dw_cnt  <= '0;
            tlp_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            dw_cnt <= dw_nxt;
            if (force_last) begin
                tlp_err <= 1'b1;
            end
        end
    end

    assign tlp_push_data = {fifo_rx_data[63:11], fifo_rx_data[10] | force_last,
                            fifo_rx_data[9:0]};
`else
    logic unused_max_tlp_dw;

    assign unused_max_tlp_dw = ^MAX_TLP_DW;
    assign tlp_push_data     = fifo_rx_data;
    assign tlp_err           = 1'b0;
`endif

    pcileech_fifo_rx_skid #(
        .W (64)
    ) u_tlp_buf (
        .clk       (user_clk),
        .rst_n     (user_reset_n),
        .push      (is_tlp),
        .push_data (tlp_push_data),
        .ready     (pcie_tlp_rx_ready),
        .data      (pcie_tlp_rx_data),
        .valid     (pcie_tlp_rx_valid),
        .cnt       (tlp_cnt)
    );

    pcileech_fifo_rx_skid #(
        .W (64)
    ) u_cfg_buf (
        .clk       (user_clk),
        .rst_n     (user_reset_n),
        .push      (is_cfg),
        .push_data (fifo_rx_data),
        .ready     (pcie_cfg_rx_ready),
        .data      (pcie_cfg_rx_data),
        .valid     (pcie_cfg_rx_valid),
        .cnt       (cfg_cnt)
    );
endmodule
`default_nettype wire

// File: tb/tb_pcileech_fifo_rx_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcileech_fifo_rx_demux
// Description : Scoreboard bench for pcileech_fifo_rx_demux. Stimulus pushes
//               hand-computed expected words into per-stream queues when the
//               DUT accepts them; a monitor pops and compares on each output
//               transfer and checks that stalled outputs hold steady.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcileech_fifo_rx_demux;
`ifdef PCILEECH_RX_TLP_CHECK_EN
    localparam bit EXP_CHK = 1'b1;
`else
    localparam bit EXP_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] tlp_data;
    logic        tlp_valid;
    logic        tlp_ready;
    logic [63:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] drop_cnt;
    logic        tlp_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] tlp_q[$];
    logic [63:0] cfg_q[$];

    always #5 clk = ~clk;

    pcileech_fifo_rx_demux #(
        .MAX_TLP_DW (4),
        .CNT_W      (16)
    ) dut (
        .user_clk          (clk),
        .user_reset_n      (rst_n),
        .fifo_rx_data      (in_data),
        .fifo_rx_valid     (in_valid),
        .fifo_rx_ready     (in_ready),
        .pcie_tlp_rx_data  (tlp_data),
        .pcie_tlp_rx_valid (tlp_valid),
        .pcie_tlp_rx_ready (tlp_ready),
        .pcie_cfg_rx_data  (cfg_data),
        .pcie_cfg_rx_valid (cfg_valid),
        .pcie_cfg_rx_ready (cfg_ready),
        .drop_cnt          (drop_cnt),
        .tlp_err           (tlp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // dest: 0 = dropped, 1 = TLP stream, 2 = CFG stream
    task automatic send(input logic [63:0] w, input int dest, input logic [63:0] exp);
        bit acc;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 200; n++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else if (dest == 1) begin
            tlp_q.push_back(exp);
        end else if (dest == 2) begin
            cfg_q.push_back(exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((tlp_q.size() != 0 || cfg_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(tlp_q.size() + cfg_q.size()), 64'd0);
    endtask

    // Monitor: compares transfers against the queues and checks that a
    // stalled output keeps valid and data steady.
    bit          tlp_hold = 1'b0;
    bit          cfg_hold = 1'b0;
    logic [63:0] tlp_hold_data;
    logic [63:0] cfg_hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            tlp_hold = 1'b0;
            cfg_hold = 1'b0;
        end else begin
            if (tlp_hold) chk("tlp_stable", {tlp_valid, tlp_data}, {1'b1, tlp_hold_data});
            if (cfg_hold) chk("cfg_stable", {cfg_valid, cfg_data}, {1'b1, cfg_hold_data});
            tlp_hold = tlp_valid && !tlp_ready;
            cfg_hold = cfg_valid && !cfg_ready;
            tlp_hold_data = tlp_data;
            cfg_hold_data = cfg_data;
            if (tlp_valid && tlp_ready) begin
                if (tlp_q.size() == 0) chk("tlp_unexpected", tlp_data, 64'hX);
                else chk("tlp_data", tlp_data, tlp_q.pop_front());
            end
            if (cfg_valid && cfg_ready) begin
                if (cfg_q.size() == 0) chk("cfg_unexpected", cfg_data, 64'hX);
                else chk("cfg_data", cfg_data, cfg_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] w;
        rst_n     = 1'b0;
        in_data   = 64'd0;
        in_valid  = 1'b0;
        tlp_ready = 1'b1;
        cfg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {62'd0, tlp_valid, cfg_valid}, 64'd0);
        chk("rst_tlp_data", tlp_data, 64'd0);
        chk("rst_cfg_data", cfg_data, 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_err", 64'(tlp_err), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Test 1: three-word TLP, full throughput.
        send(64'h0000_00A0_0000_0377, 1, 64'h0000_00A0_0000_0377);
        #1 chk("t1_latency", 64'(tlp_valid), 64'd1);
        send(64'h0000_00A1_0000_0377, 1, 64'h0000_00A1_0000_0377);
        send(64'h0000_00A2_0000_0777, 1, 64'h0000_00A2_0000_0777);
        idle();
        drain("t1_drain");
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // Test 2: CFG word.
        send(64'h0000_0004_0000_0077, 2, 64'h0000_0004_0000_0077);
        #1 chk("t2_valids", {62'd0, cfg_valid, tlp_valid}, 64'd2);
        idle();
        drain("t2_drain");

        // Test 3: dropped words, then saturation.
        send(64'h0000_00C0_0000_0376, 0, 64'd0);
        send(64'h0000_00C1_0000_0177, 0, 64'd0);
        idle();
        @(posedge clk);
        #1 chk("t3_drop2", 64'(drop_cnt), 64'd2);
        chk("t3_no_valid", {62'd0, tlp_valid, cfg_valid}, 64'd0);
        @(negedge clk);
        in_data  = 64'h0000_00C2_0000_0376;
        in_valid = 1'b1;
        repeat (65537) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("t3_saturate", 64'(drop_cnt), 64'h0000_0000_0000_FFFF);

        // Test 4: backpressure on the TLP stream stalls both streams.
        @(posedge clk);
        #1 tlp_ready = 1'b0;
        send(64'h0000_00D0_0000_0377, 1, 64'h0000_00D0_0000_0377);
        send(64'h0000_00D1_0000_0377, 1, 64'h0000_00D1_0000_0377);
        @(negedge clk);
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        fork
            begin
                send(64'h0000_00D2_0000_0777, 1, 64'h0000_00D2_0000_0777);
                send(64'h0000_0005_0000_0077, 2, 64'h0000_0005_0000_0077);
            end
            begin
                repeat (4) @(negedge clk);
                chk("t4_stall_ready", 64'(in_ready), 64'd0);
                chk("t4_cfg_stalled", 64'(cfg_valid), 64'd0);
                @(posedge clk);
                #1 tlp_ready = 1'b1;
            end
        join
        idle();
        drain("t4_drain");

        // Test 5: six untermintated TLP words against MAX_TLP_DW = 4.
        for (int k = 1; k <= 6; k++) begin
            w = 64'h0000_00E0_0000_0377 | (64'(k) << 32);
            if (EXP_CHK && k == 4) send(w, 1, w | 64'h400);
            else send(w, 1, w);
        end
        send(64'h0000_00E7_0000_0777, 1, 64'h0000_00E7_0000_0777);
        idle();
        drain("t5_drain");
        chk("t5_tlp_err", 64'(tlp_err), 64'(EXP_CHK));

        // Test 6: reset with a partial TLP held in the buffer.
        @(posedge clk);
        #1 tlp_ready = 1'b0;
        send(64'h0000_00F0_0000_0377, 1, 64'h0000_00F0_0000_0377);
        send(64'h0000_00F1_0000_0377, 1, 64'h0000_00F1_0000_0377);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_valids", {62'd0, tlp_valid, cfg_valid}, 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        chk("t6_err", 64'(tlp_err), 64'd0);
        tlp_q.delete();
        cfg_q.delete();
        rst_n     = 1'b1;
        tlp_ready = 1'b1;
        send(64'h0000_00F2_0000_0777, 1, 64'h0000_00F2_0000_0777);
        #1 chk("t6_latency", 64'(tlp_valid), 64'd1);
        idle();
        drain("t6_drain");
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
